// File: rtl/disp_pkg.sv
// Shared display definitions: digit count, anode encoding and scan FSM states.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [3:0]  ANODE_OFF  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LIT,
    ST_GUARD
  } scan_state_e;

  // Active-low one-cold anode pattern for digit index idx (0 = rightmost).
  function automatic logic [3:0] anode_on(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; tc flags the last cycle of the loaded interval.
module scan_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/scan_ctrl.sv
// Four-digit multiplexed display scanner with guard gaps, frame-aligned
// digit commit through a one-entry pending buffer, and leading-zero blanking.
module scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned GUARD_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        lz_en,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  digit4,
  output logic [1:0]  refreshcounter,
  output logic [3:0]  anode,
  output logic        frame_done
);

  localparam int unsigned MAX_CYCLES = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  scan_state_e      state;
  logic             tc;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic [1:0]       next_idx;
  logic             last_digit;
  logic             commit;
  logic [3:0]       blank;
  logic             pending;
  logic [15:0]      pend_data;

  scan_timer #(.WIDTH(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .tc       (tc)
  );

  // A digit blanks when it and every digit to its left are zero.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (digit4 == 4'd0);
    blank[2] = blank[3] && (digit3 == 4'd0);
    blank[1] = blank[2] && (digit2 == 4'd0);
  end

  function automatic logic [3:0] lit_anode(input logic [1:0] idx, input logic lz,
                                           input logic [3:0] blk);
    return (lz && blk[idx]) ? ANODE_OFF : anode_on(idx);
  endfunction

  assign next_idx   = refreshcounter + 2'd1;
  assign last_digit = (refreshcounter == 2'(NUM_DIGITS - 1));
  assign commit     = pending && ((state == ST_IDLE) ||
                                  (state == ST_LIT && tc && last_digit && enable));

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    timer_load = 1'b1;
    timer_val  = '0;
    case (state)
      ST_IDLE:  timer_val = enable ? DIGIT_LAST : '0;
      ST_LIT: begin
        timer_load = tc;
        timer_val  = GUARD_LAST;
      end
      ST_GUARD: begin
        timer_load = tc;
        timer_val  = DIGIT_LAST;
      end
      default:  timer_val = '0;
    endcase
    if (!enable) begin
      timer_load = 1'b1;
      timer_val  = '0;
    end
  end

  // Scan FSM; the anode index only moves while every anode is dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      refreshcounter <= 2'd0;
      anode          <= ANODE_OFF;
      frame_done     <= 1'b0;
    end else if (!enable) begin
      state          <= ST_IDLE;
      refreshcounter <= 2'd0;
      anode          <= ANODE_OFF;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          state          <= ST_LIT;
          refreshcounter <= 2'd0;
          anode          <= lit_anode(2'd0, lz_en, blank);
        end
        ST_LIT: begin
          if (tc) begin
            state      <= ST_GUARD;
            anode      <= ANODE_OFF;
            frame_done <= last_digit;
          end
        end
        ST_GUARD: begin
          if (tc) begin
            state          <= ST_LIT;
            refreshcounter <= next_idx;
            anode          <= lit_anode(next_idx, lz_en, blank);
          end
        end
        default: begin
          state          <= ST_IDLE;
          refreshcounter <= 2'd0;
          anode          <= ANODE_OFF;
        end
      endcase
    end
  end

  // Load handshake and frame-aligned commit; capture and commit never
  // coincide because capture requires an empty slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      pend_data  <= 16'h0000;
      load_ready <= 1'b1;
      digit1     <= 4'd0;
      digit2     <= 4'd0;
      digit3     <= 4'd0;
      digit4     <= 4'd0;
    end else if (commit) begin
      pending    <= 1'b0;
      load_ready <= 1'b1;
      digit1     <= pend_data[3:0];
      digit2     <= pend_data[7:4];
      digit3     <= pend_data[11:8];
      digit4     <= pend_data[15:12];
    end else if (load_valid && load_ready) begin
      pending    <= 1'b1;
      pend_data  <= load_data;
      load_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_ctrl.sv
// Scoreboard bench for scan_ctrl with short digit/guard periods.
module tb_scan_ctrl;

  localparam int unsigned DC = 4;
  localparam int unsigned GC = 1;
  localparam int unsigned FRAME = 4 * (DC + GC);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        lz_en = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0000;
  logic        load_ready;
  logic [3:0]  digit1, digit2, digit3, digit4;
  logic [1:0]  refreshcounter;
  logic [3:0]  anode;
  logic        frame_done;

  typedef struct packed {
    logic [3:0] anode;
    logic [1:0] rc;
    logic       fd;
  } scan_exp_t;

  scan_exp_t   sb_scan[$];
  logic [15:0] sb_digits[$];

  int pass_count = 0;
  int check_count = 0;

  scan_ctrl #(.DIGIT_CYCLES(DC), .GUARD_CYCLES(GC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .lz_en          (lz_en),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_ready     (load_ready),
    .digit1         (digit1),
    .digit2         (digit2),
    .digit3         (digit3),
    .digit4         (digit4),
    .refreshcounter (refreshcounter),
    .anode          (anode),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  // One frame of expectations from frame position; blk marks dark digit slots.
  task automatic push_frame(input logic [3:0] blk);
    scan_exp_t e;
    for (int pos = 0; pos < int'(FRAME); pos++) begin
      int idx = pos / int'(DC + GC);
      int p   = pos % int'(DC + GC);
      e.rc    = 2'(idx);
      e.fd    = (idx == 3) && (p == int'(DC));
      if (p >= int'(DC) || blk[idx]) e.anode = 4'b1111;
      else                           e.anode = ~(4'b0001 << idx);
      sb_scan.push_back(e);
    end
  endtask

  task automatic run_scan(input int cycles);
    scan_exp_t e;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_count++;
      if (sb_scan.size() == 0) begin
        $display("FAIL scan_queue cycle %0d: queue empty, required an entry", i);
      end else begin
        e = sb_scan.pop_front();
        if ({anode, refreshcounter, frame_done} !== e)
          $display("FAIL scan cycle %0d: anode=%b rc=%0d fd=%b, required anode=%b rc=%0d fd=%b",
                   i, anode, refreshcounter, frame_done, e.anode, e.rc, e.fd);
        else pass_count++;
      end
    end
  endtask

  task automatic check_digits(input string name);
    logic [15:0] exp;
    check_count++;
    if (sb_digits.size() == 0) begin
      $display("FAIL %s: digit queue empty", name);
    end else begin
      exp = sb_digits.pop_front();
      if ({digit4, digit3, digit2, digit1} !== exp)
        $display("FAIL %s: digits=%h, required %h", name, {digit4, digit3, digit2, digit1}, exp);
      else pass_count++;
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    check_count++;
    if (got !== exp) $display("FAIL %s: got %b, required %b", name, got, exp);
    else pass_count++;
  endtask

  task automatic check_nib(input string name, input logic [15:0] got, input logic [15:0] exp);
    check_count++;
    if (got !== exp) $display("FAIL %s: got %h, required %h", name, got, exp);
    else pass_count++;
  endtask

  task automatic wait_frame_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3 * int'(FRAME); i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check_count++;
      $display("FAIL %s: frame_done timeout, required a pulse within %0d cycles", name, 3 * FRAME);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_nib("reset_anode", {12'h0, anode}, 16'h000F);
    check_nib("reset_rc", {14'h0, refreshcounter}, 16'h0000);
    check_nib("reset_digits", {digit4, digit3, digit2, digit1}, 16'h0000);
    check_bit("reset_load_ready", load_ready, 1'b1);
    check_bit("reset_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_nib("idle_anode", {12'h0, anode}, 16'h000F);
  endtask

  task automatic test_scan();
    enable = 1'b1;
    push_frame(4'b0000);
    push_frame(4'b0000);
    run_scan(2 * int'(FRAME));
  endtask

  task automatic test_load();
    bit early = 1'b0;
    bit seen = 1'b0;
    repeat (3) @(negedge clk);
    load_valid = 1'b1;
    load_data  = 16'h1234;
    sb_digits.push_back(16'h1234);
    @(negedge clk);
    load_valid = 1'b0;
    check_bit("load_ready_low", load_ready, 1'b0);
    for (int i = 0; i < 3 * int'(FRAME); i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if ({digit4, digit3, digit2, digit1} !== 16'h0000) early = 1'b1;
    end
    check_bit("load_frame_done_seen", seen, 1'b1);
    check_bit("digits_changed_early", early, 1'b0);
    check_digits("commit_1234");
    check_bit("load_ready_after_commit", load_ready, 1'b1);
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    repeat (2) @(negedge clk);
    load_valid = 1'b1;
    load_data  = 16'h1111;
    sb_digits.push_back(16'h1111);
    @(negedge clk);
    load_data = 16'hABCD;
    check_bit("b2b_ready_low", load_ready, 1'b0);
    for (int i = 0; i < 3 * int'(FRAME); i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check_bit("b2b_frame_done_seen", seen, 1'b1);
    check_digits("b2b_first_not_overwritten");
    check_bit("b2b_ready_after_commit", load_ready, 1'b1);
    sb_digits.push_back(16'hABCD);
    @(negedge clk);
    load_valid = 1'b0;
    check_bit("b2b_second_accepted", load_ready, 1'b0);
    wait_frame_done("b2b_second");
    check_digits("b2b_commit_abcd");
  endtask

  task automatic test_lz();
    lz_en      = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h0050;
    sb_digits.push_back(16'h0050);
    @(negedge clk);
    load_valid = 1'b0;
    wait_frame_done("lz_commit");
    check_digits("lz_commit_0050");
    push_frame(4'b1100);
    run_scan(int'(FRAME));
  endtask

  task automatic test_enable_drop();
    lz_en = 1'b0;
    repeat (7) @(negedge clk);
    check_nib("drop_pre_anode", {12'h0, anode}, 16'h000D);
    enable = 1'b0;
    @(negedge clk);
    check_nib("drop_anode_off", {12'h0, anode}, 16'h000F);
    check_nib("drop_rc_zero", {14'h0, refreshcounter}, 16'h0000);
    enable = 1'b1;
    @(negedge clk);
    check_nib("reenable_anode", {12'h0, anode}, 16'h000E);
    check_nib("reenable_rc", {14'h0, refreshcounter}, 16'h0000);
  endtask

  task automatic test_reset_pending();
    @(negedge clk);
    check_bit("rp_ready_before", load_ready, 1'b1);
    load_valid = 1'b1;
    load_data  = 16'h9999;
    @(negedge clk);
    load_valid = 1'b0;
    check_bit("rp_pending_taken", load_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_nib("rp_async_anode", {12'h0, anode}, 16'h000F);
    check_nib("rp_async_digits", {digit4, digit3, digit2, digit1}, 16'h0000);
    check_bit("rp_async_ready", load_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_nib("rp_restart_anode", {12'h0, anode}, 16'h000E);
    check_nib("rp_restart_rc", {14'h0, refreshcounter}, 16'h0000);
    wait_frame_done("rp_frame");
    check_nib("rp_digits_discarded", {digit4, digit3, digit2, digit1}, 16'h0000);
    check_bit("rp_ready_after", load_ready, 1'b1);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_lz();
    test_enable_drop();
    test_reset_pending();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
